// File: rtl/pwm_deadtime_if.sv
// Peripheral register bus shared by the perips: write data, address,
// write enable toward the block and combinational read data back.
interface pwm_deadtime_if;

    logic [31:0] data_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] data_o;

    // Bus owner drives the request side and samples read data.
    modport master (
        output data_i,
        output addr_i,
        output we_i,
        input  data_o
    );

    // Peripheral side receives requests and returns read data.
    modport slave (
        input  data_i,
        input  addr_i,
        input  we_i,
        output data_o
    );

endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage. Each raw PWM bit becomes a
// high-side/low-side pair with a programmable dead band on every
// transition. A latched fault forces every channel idle with both
// outputs low until software clears it.
module pwm_deadtime #(
    parameter int CHANNEL = 4,
    parameter int DT_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    pwm_deadtime_if.slave      bus,
    input  logic [CHANNEL-1:0] pwm_i,
    input  logic               fault_i,
    output logic [CHANNEL-1:0] pwm_h_o,
    output logic [CHANNEL-1:0] pwm_l_o
);

    localparam logic [7:0] ADDR_EN     = 8'h10;
    localparam logic [7:0] ADDR_STATUS = 8'h11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEAD_HI = 3'd1,
        HI      = 3'd2,
        DEAD_LO = 3'd3,
        LO      = 3'd4
    } state_t;

    logic [7:0]         w_addrInner;
    logic               w_wrStatus;
    logic               w_clearReq;
    logic [31:0]        w_rdata;
    logic               w_unused;

    logic [DT_W-1:0]    r_dt [CHANNEL];
    logic [CHANNEL-1:0] r_en;
    logic               r_faultLat;
    logic [CHANNEL-1:0] r_p;

    state_t             r_state     [CHANNEL];
    state_t             w_stateNext [CHANNEL];
    logic [DT_W-1:0]    r_cnt       [CHANNEL];
    logic [DT_W-1:0]    w_cntNext   [CHANNEL];
    logic [CHANNEL-1:0] w_hold;
    logic [CHANNEL-1:0] w_hNext;
    logic [CHANNEL-1:0] w_lNext;

    assign w_addrInner = bus.addr_i[23:16];
    assign w_wrStatus  = bus.we_i && (w_addrInner == ADDR_STATUS);
    // A clear that coincides with an active fault loses to the fault.
    assign w_clearReq  = w_wrStatus && bus.data_i[0] && !fault_i;

    // Only some address and data bits select or carry register contents.
    assign w_unused = ^{bus.addr_i, bus.data_i};

    // A channel is held idle when disabled, when a fault is latched, or
    // on the very edge that latches a new fault.
    assign w_hold = ~r_en | {CHANNEL{r_faultLat | fault_i}};

    // Register writes: dead-time per channel, enable mask, fault latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CHANNEL; i++) begin
                r_dt[i] <= '0;
            end
            r_en       <= '0;
            r_faultLat <= 1'b0;
        end else begin
            if (bus.we_i) begin
                for (int i = 0; i < CHANNEL; i++) begin
                    if (w_addrInner == 8'(i)) begin
                        r_dt[i] <= bus.data_i[DT_W-1:0];
                    end
                end
                if (w_addrInner == ADDR_EN) begin
                    r_en <= bus.data_i[CHANNEL-1:0];
                end
            end
            if (fault_i) begin
                r_faultLat <= 1'b1;
            end else if (w_clearReq) begin
                r_faultLat <= 1'b0;
            end
        end
    end

    // Combinational read-back; anything outside the map reads as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            if (w_addrInner == 8'(i)) begin
                w_rdata = 32'(r_dt[i]);
            end
        end
        if (w_addrInner == ADDR_EN) begin
            w_rdata = 32'(r_en);
        end
        if (w_addrInner == ADDR_STATUS) begin
            w_rdata = {30'b0, fault_i, r_faultLat};
        end
    end

    assign bus.data_o = w_rdata;

    // Capture the raw PWM once; every FSM decision looks only at this copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p <= '0;
        end else begin
            r_p <= pwm_i;
        end
    end

    // Per-channel next state, dead counter and output decode.
    always_comb begin
        for (int i = 0; i < CHANNEL; i++) begin
            w_stateNext[i] = r_state[i];
            w_cntNext[i]   = r_cnt[i];
            if (w_hold[i]) begin
                w_stateNext[i] = IDLE;
                w_cntNext[i]   = '0;
            end else begin
                case (r_state[i])
                    IDLE: begin
                        w_stateNext[i] = r_p[i] ? DEAD_HI : DEAD_LO;
                        w_cntNext[i]   = r_dt[i];
                    end
                    DEAD_HI: begin
                        if (!r_p[i]) begin
                            w_stateNext[i] = DEAD_LO;
                            w_cntNext[i]   = r_dt[i];
                        end else if (r_cnt[i] == '0) begin
                            w_stateNext[i] = HI;
                        end else begin
                            w_cntNext[i] = r_cnt[i] - DT_W'(1);
                        end
                    end
                    HI: begin
                        if (!r_p[i]) begin
                            w_stateNext[i] = DEAD_LO;
                            w_cntNext[i]   = r_dt[i];
                        end
                    end
                    DEAD_LO: begin
                        if (r_p[i]) begin
                            w_stateNext[i] = DEAD_HI;
                            w_cntNext[i]   = r_dt[i];
                        end else if (r_cnt[i] == '0) begin
                            w_stateNext[i] = LO;
                        end else begin
                            w_cntNext[i] = r_cnt[i] - DT_W'(1);
                        end
                    end
                    LO: begin
                        if (r_p[i]) begin
                            w_stateNext[i] = DEAD_HI;
                            w_cntNext[i]   = r_dt[i];
                        end
                    end
                    default: begin
                        w_stateNext[i] = IDLE;
                        w_cntNext[i]   = '0;
                    end
                endcase
            end
            w_hNext[i] = (w_stateNext[i] == HI);
            w_lNext[i] = (w_stateNext[i] == LO);
        end
    end

    // State, counters and drive outputs all advance on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CHANNEL; i++) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
            end
            pwm_h_o <= '0;
            pwm_l_o <= '0;
        end else begin
            for (int i = 0; i < CHANNEL; i++) begin
                r_state[i] <= w_stateNext[i];
                r_cnt[i]   <= w_cntNext[i];
            end
            pwm_h_o <= w_hNext;
            pwm_l_o <= w_lNext;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: dead-band timing, glitch rejection,
// fault latch handling and asynchronous reset.
module tb_pwm_deadtime;

    localparam int CHANNEL = 4;

    logic               clk_i;
    logic               rst_ni;
    logic [CHANNEL-1:0] pwm_i;
    logic               fault_i;
    logic [CHANNEL-1:0] pwm_h_o;
    logic [CHANNEL-1:0] pwm_l_o;

    int checkCount;
    int failCount;
    int overlapCount;

    logic [15:0] expH;
    logic [15:0] expL;
    logic [31:0] rd;

    pwm_deadtime_if busIf ();

    pwm_deadtime #(
        .CHANNEL (CHANNEL),
        .DT_W    (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .bus     (busIf.slave),
        .pwm_i   (pwm_i),
        .fault_i (fault_i),
        .pwm_h_o (pwm_h_o),
        .pwm_l_o (pwm_l_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Both sides of a pair must never be on together.
    always @(negedge clk_i) begin
        if (rst_ni && ((pwm_h_o & pwm_l_o) != '0)) begin
            overlapCount++;
        end
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the PWM and fault inputs for the coming edge.
    task automatic applyStimulus(input logic [CHANNEL-1:0] pwm, input logic fault);
        pwm_i   = pwm;
        fault_i = fault;
    endtask

    // One bus write, committed on the next rising edge.
    task automatic writeReg(input logic [7:0] regAddr, input logic [31:0] value);
        busIf.addr_i = {8'h00, regAddr, 16'h0000};
        busIf.data_i = value;
        busIf.we_i   = 1'b1;
        tick();
        busIf.we_i   = 1'b0;
    endtask

    // Combinational read-back of one register.
    task automatic readReg(input logic [7:0] regAddr, output logic [31:0] value);
        busIf.addr_i = {8'h00, regAddr, 16'h0000};
        #1;
        value = busIf.data_o;
    endtask

    // Check both output vectors at once.
    task automatic checkPair(input string tag, input logic [CHANNEL-1:0] h, input logic [CHANNEL-1:0] l);
        checkOutput({tag, "_h"}, 32'(pwm_h_o), 32'(h));
        checkOutput({tag, "_l"}, 32'(pwm_l_o), 32'(l));
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        overlapCount = 0;
        rst_ni       = 1'b0;
        busIf.addr_i = '0;
        busIf.data_i = '0;
        busIf.we_i   = 1'b0;
        applyStimulus('0, 1'b0);
        #12;
        rst_ni = 1'b1;
        tick();

        $display("[TB] reset state");
        checkPair("reset", 4'b0000, 4'b0000);
        readReg(8'h11, rd);
        checkOutput("reset_status", rd, 32'h0);
        readReg(8'h10, rd);
        checkOutput("reset_en", rd, 32'h0);

        $display("[TB] first drive after enable, DT=3");
        writeReg(8'h00, 32'h3);
        readReg(8'h00, rd);
        checkOutput("dt0_readback", rd, 32'h3);
        applyStimulus(4'b0001, 1'b0);
        writeReg(8'h10, 32'h1);
        checkPair("start_capture", 4'b0000, 4'b0000);
        repeat (4) tick();
        checkPair("start_dead_end", 4'b0000, 4'b0000);
        tick();
        checkPair("start_hi", 4'b0001, 4'b0000);
        repeat (3) tick();
        checkPair("start_hi_steady", 4'b0001, 4'b0000);

        $display("[TB] falling edge latency, DT=3");
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkPair("fall_k", 4'b0001, 4'b0000);
        tick();
        checkPair("fall_k1", 4'b0000, 4'b0000);
        repeat (3) tick();
        checkPair("fall_k4", 4'b0000, 4'b0000);
        tick();
        checkPair("fall_k5", 4'b0000, 4'b0001);

        $display("[TB] DT=0 toggling every 4 cycles");
        writeReg(8'h00, 32'h0);
        expH = 16'h1C1C;
        expL = 16'hC1C1;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(((j / 4) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
            tick();
            checkOutput("dt0_toggle_h", 32'(pwm_h_o[0]), 32'(expH[j]));
            checkOutput("dt0_toggle_l", 32'(pwm_l_o[0]), 32'(expL[j]));
        end

        $display("[TB] short glitch with DT=5");
        applyStimulus(4'b0001, 1'b0);
        writeReg(8'h00, 32'h5);
        repeat (10) tick();
        checkPair("glitch_pre_hi", 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        checkPair("glitch_dead_lo", 4'b0000, 4'b0000);
        applyStimulus(4'b0001, 1'b0);
        for (int j = 0; j < 7; j++) begin
            tick();
            checkPair("glitch_dead", 4'b0000, 4'b0000);
        end
        tick();
        checkPair("glitch_hi_back", 4'b0001, 4'b0000);

        $display("[TB] four channels and fault handling");
        writeReg(8'h00, 32'h2);
        writeReg(8'h01, 32'h1);
        writeReg(8'h02, 32'h2);
        writeReg(8'h03, 32'h3);
        applyStimulus(4'b0101, 1'b0);
        writeReg(8'h10, 32'hF);
        readReg(8'h10, rd);
        checkOutput("en_readback", rd, 32'hF);
        readReg(8'h12, rd);
        checkOutput("unmapped_12", rd, 32'h0);
        readReg(8'h04, rd);
        checkOutput("unmapped_04", rd, 32'h0);
        repeat (12) tick();
        checkPair("all_running", 4'b0101, 4'b1010);

        applyStimulus(4'b0101, 1'b1);
        tick();
        applyStimulus(4'b0101, 1'b0);
        checkPair("fault_off", 4'b0000, 4'b0000);
        readReg(8'h11, rd);
        checkOutput("fault_status", rd, 32'h1);
        repeat (3) tick();
        checkPair("fault_held", 4'b0000, 4'b0000);

        applyStimulus(4'b0101, 1'b1);
        writeReg(8'h11, 32'h1);
        readReg(8'h11, rd);
        checkOutput("clear_blocked", rd, 32'h3);
        applyStimulus(4'b0101, 1'b0);
        readReg(8'h11, rd);
        checkOutput("clear_blocked_lat", rd, 32'h1);

        writeReg(8'h11, 32'h1);
        readReg(8'h11, rd);
        checkOutput("clear_ok", rd, 32'h0);
        checkPair("clear_c", 4'b0000, 4'b0000);
        tick();
        checkPair("clear_c1", 4'b0000, 4'b0000);
        repeat (3) tick();
        checkPair("clear_c4", 4'b0101, 4'b0010);
        tick();
        checkPair("clear_c5", 4'b0101, 4'b1010);

        $display("[TB] asynchronous reset mid dead band");
        applyStimulus(4'b1011, 1'b0);
        tick();
        tick();
        checkPair("pre_reset_dead", 4'b0001, 4'b0000);
        #2;
        rst_ni = 1'b0;
        #1;
        checkPair("async_reset", 4'b0000, 4'b0000);
        #2;
        rst_ni = 1'b1;
        tick();
        readReg(8'h00, rd);
        checkOutput("post_reset_dt0", rd, 32'h0);
        readReg(8'h03, rd);
        checkOutput("post_reset_dt3", rd, 32'h0);
        readReg(8'h10, rd);
        checkOutput("post_reset_en", rd, 32'h0);
        readReg(8'h11, rd);
        checkOutput("post_reset_status", rd, 32'h0);
        checkPair("post_reset_out", 4'b0000, 4'b0000);

        checkOutput("no_overlap", 32'(overlapCount), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
